// File: rtl/palette_dp.sv
// Dual-port PPU palette memory: registered CPU read/write port plus a two-stage render lookup.
// Contents are cleared by an init sequencer after every reset.
module palette_dp #(
    parameter int unsigned DATA_W    = 6,
    parameter int unsigned ENTRIES   = 32,
    parameter bit          MIRROR_BG = 1'b1,
    parameter logic [7:0]  INIT_VAL  = 8'h0F,
    localparam int unsigned AW       = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     cpu_addr,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic [7:0]        cpu_data_i,
    output logic [7:0]        cpu_data_o,
    output logic              cpu_rvalid,
    input  logic              pix_valid,
    input  logic [AW-1:0]     pix_idx,
    input  logic              greyscale,
    input  logic [2:0]        emph,
    output logic              pix_valid_o,
    output logic [DATA_W-1:0] pix_color,
    output logic [2:0]        pix_emph,
    output logic              busy
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [ENTRIES];

    logic [AW-1:0]     cpu_eff, pix_eff;
    logic [7:0]        cpu_rd_ext;
    logic [7:0]        cpu_data_q;
    logic              cpu_rvalid_q;

    logic              s1_valid_q, s1_grey_q;
    logic [2:0]        s1_emph_q;
    logic [DATA_W-1:0] s1_data_q;
    logic              pix_valid_q;
    logic [DATA_W-1:0] pix_color_q;
    logic [2:0]        pix_emph_q;

    logic              unused_data;

    // Backdrop entries (addr[1:0]==0) of the upper half alias onto the lower half.
    function automatic logic [AW-1:0] eff_addr(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = a;
        if (MIRROR_BG && a[1:0] == 2'b00) begin
            r[AW-1] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] grey_mask(input logic [DATA_W-1:0] d, input logic g);
        logic [DATA_W-1:0] r;
        r = d;
        if (g) begin
            r[3:0] = 4'h0;
        end
        return r;
    endfunction

    assign cpu_eff     = eff_addr(cpu_addr);
    assign pix_eff     = eff_addr(pix_idx);
    assign unused_data = ^cpu_data_i;

    always_comb begin
        cpu_rd_ext = '0;
        cpu_rd_ext[DATA_W-1:0] = grey_mask(mem[cpu_eff], greyscale);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(ENTRIES - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // No reset on the array: the sequencer owns initialisation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StInit) begin
                mem[cnt_q] <= INIT_VAL[DATA_W-1:0];
            end else if (cpu_wr) begin
                mem[cpu_eff] <= cpu_data_i[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid_q <= 1'b0;
            cpu_data_q   <= '0;
        end else begin
            cpu_rvalid_q <= cpu_rd;
            if (cpu_rd) begin
                cpu_data_q <= (state_q == StInit) ? 8'h00 : cpu_rd_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_grey_q   <= 1'b0;
            s1_emph_q   <= '0;
            s1_data_q   <= '0;
            pix_valid_q <= 1'b0;
            pix_color_q <= '0;
            pix_emph_q  <= '0;
        end else begin
            s1_valid_q  <= pix_valid && (state_q == StRun);
            s1_grey_q   <= greyscale;
            s1_emph_q   <= emph;
            s1_data_q   <= mem[pix_eff];
            pix_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                pix_color_q <= grey_mask(s1_data_q, s1_grey_q);
                pix_emph_q  <= s1_emph_q;
            end
        end
    end

    assign cpu_data_o  = cpu_data_q;
    assign cpu_rvalid  = cpu_rvalid_q;
    assign pix_valid_o = pix_valid_q;
    assign pix_color   = pix_color_q;
    assign pix_emph    = pix_emph_q;
    assign busy        = (state_q == StInit);

endmodule

// File: tb/tb_palette_dp.sv
// Directed bench for palette_dp: init sequencing, mirroring, read-before-write,
// render pipeline and write/render collision.
module tb_palette_dp;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] cpu_addr;
    logic       cpu_wr, cpu_rd;
    logic [7:0] cpu_data_i;
    logic [7:0] cpu_data_o;
    logic       cpu_rvalid;
    logic       pix_valid;
    logic [4:0] pix_idx;
    logic       greyscale;
    logic [2:0] emph;
    logic       pix_valid_o;
    logic [5:0] pix_color;
    logic [2:0] pix_emph;
    logic       busy;

    int checks = 0;
    int errors = 0;

    palette_dp dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wr     (cpu_wr),
        .cpu_rd     (cpu_rd),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .cpu_rvalid (cpu_rvalid),
        .pix_valid  (pix_valid),
        .pix_idx    (pix_idx),
        .greyscale  (greyscale),
        .emph       (emph),
        .pix_valid_o(pix_valid_o),
        .pix_color  (pix_color),
        .pix_emph   (pix_emph),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
        cpu_addr   = a;
        cpu_data_i = d;
        cpu_wr     = 1'b1;
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [4:0] a, input logic [7:0] exp);
        cpu_addr = a;
        cpu_rd   = 1'b1;
        tick();
        cpu_rd = 1'b0;
        check({tag, "_rvalid"}, cpu_rvalid, 1);
        check(tag, cpu_data_o, exp);
    endtask

    // Counts busy cycles from the current sample point, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    int n;

    initial begin
        rst = 1'b1; cpu_addr = '0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_data_i = '0;
        pix_valid = 1'b0; pix_idx = '0; greyscale = 1'b0; emph = '0;
        tick();
        tick();
        check("rst_busy", busy, 1);
        check("rst_rvalid", cpu_rvalid, 0);
        check("rst_pix_valid", pix_valid_o, 0);
        check("rst_cpu_data", cpu_data_o, 0);
        check("rst_pix_color", pix_color, 0);
        check("rst_pix_emph", pix_emph, 0);

        // Init with render and CPU read requests held active
        rst = 1'b0; pix_valid = 1'b1; cpu_rd = 1'b1; cpu_addr = 5'd5;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
            if (pix_valid_o !== 1'b0) check("init_pix_valid", pix_valid_o, 0);
            if (cpu_data_o !== 8'h00) check("init_cpu_data", cpu_data_o, 0);
            if (n == 5) check("init_rvalid", cpu_rvalid, 1);
        end
        check("init_busy_cycles", n, 32);
        pix_valid = 1'b0;
        tick();
        check("init_read5_rvalid", cpu_rvalid, 1);
        check("init_read5", cpu_data_o, 8'h0F);
        check("init_pix_after", pix_valid_o, 0);
        cpu_rd = 1'b0;
        tick();
        check("rvalid_one_cycle", cpu_rvalid, 0);
        check("cpu_data_hold", cpu_data_o, 8'h0F);

        // Backdrop mirroring
        cpu_write(5'h10, 8'h21);
        cpu_read("mir_rd00", 5'h00, 8'h21);
        cpu_read("mir_rd10", 5'h10, 8'h21);
        cpu_write(5'h14, 8'h2A);
        cpu_read("mir_rd04", 5'h04, 8'h2A);
        cpu_write(5'h11, 8'h11);
        cpu_read("nomir_rd01", 5'h01, 8'h0F);
        cpu_read("nomir_rd11", 5'h11, 8'h11);

        // Read-before-write
        cpu_addr = 5'd3; cpu_data_i = 8'h3C; cpu_wr = 1'b1; cpu_rd = 1'b1;
        tick();
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        check("rbw_old", cpu_data_o, 8'h0F);
        cpu_read("rbw_new", 5'd3, 8'h3C);
        cpu_write(5'd3, 8'hFF);
        cpu_read("trunc_ff", 5'd3, 8'h3F);
        greyscale = 1'b1;
        cpu_read("cpu_grey", 5'd3, 8'h30);
        greyscale = 1'b0;

        // Render pipeline
        cpu_write(5'd0, 8'h01);
        cpu_write(5'd1, 8'h16);
        cpu_write(5'd2, 8'h27);
        cpu_write(5'd3, 8'h38);
        pix_valid = 1'b1; pix_idx = 5'd0; emph = 3'b101; greyscale = 1'b0;
        tick();
        check("pipe_lat2", pix_valid_o, 0);
        pix_idx = 5'd1; emph = 3'b000;
        tick();
        check("pipe0_valid", pix_valid_o, 1);
        check("pipe0_color", pix_color, 6'h01);
        check("pipe0_emph", pix_emph, 3'd5);
        pix_idx = 5'd2; greyscale = 1'b1;
        tick();
        check("pipe1_valid", pix_valid_o, 1);
        check("pipe1_color", pix_color, 6'h16);
        check("pipe1_emph", pix_emph, 3'd0);
        pix_idx = 5'd3; greyscale = 1'b0;
        tick();
        check("pipe2_valid", pix_valid_o, 1);
        check("pipe2_color", pix_color, 6'h20);
        check("pipe2_emph", pix_emph, 3'd0);
        pix_valid = 1'b0; emph = 3'b111;
        tick();
        check("pipe3_valid", pix_valid_o, 1);
        check("pipe3_color", pix_color, 6'h38);
        check("pipe3_emph", pix_emph, 3'd0);
        tick();
        check("pipe_idle_valid", pix_valid_o, 0);
        check("pipe_hold_color", pix_color, 6'h38);
        check("pipe_hold_emph", pix_emph, 3'd0);
        emph = 3'b000;

        // Reset mid-init
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("midinit_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy(n);
        check("midinit_busy_cycles", n, 32);
        for (int i = 0; i < 32; i++) begin
            cpu_read($sformatf("reinit_%0d", i), 5'(i), 8'h0F);
        end

        // Write/render collision on entry 7
        pix_valid = 1'b1; pix_idx = 5'd7;
        cpu_addr = 5'd7; cpu_data_i = 8'h30; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        tick();
        pix_valid = 1'b0;
        check("coll_valid", pix_valid_o, 1);
        check("coll_old", pix_color, 6'h0F);
        tick();
        check("coll_new", pix_color, 6'h30);

        // Render through the backdrop mirror
        cpu_write(5'h10, 8'h25);
        pix_valid = 1'b1; pix_idx = 5'h00;
        tick();
        pix_idx = 5'h10;
        tick();
        pix_valid = 1'b0;
        check("rmir_00", pix_color, 6'h25);
        tick();
        check("rmir_10", pix_color, 6'h25);
        check("rmir_valid", pix_valid_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
